// File: rtl/ifft_butterfly_pipe_if.sv
// Streaming bus of the inverse-FFT butterfly: input beat, output beat and
// the sticky saturation status. The master side drives inputs, the slave is the butterfly.
interface ifft_butterfly_pipe_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a_real;
  logic [DW-1:0] a_imag;
  logic [DW-1:0] b_real;
  logic [DW-1:0] b_imag;
  logic [DW-1:0] rotation_factor_real;
  logic [DW-1:0] rotation_factor_imag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real_add;
  logic [DW-1:0] out_imag_add;
  logic [DW-1:0] out_real_sub;
  logic [DW-1:0] out_imag_sub;
  logic          sat_flag;
  logic          sat_clear;

  modport master (
    output in_valid, a_real, a_imag, b_real, b_imag,
           rotation_factor_real, rotation_factor_imag, out_ready, sat_clear,
    input  in_ready, out_valid, out_real_add, out_imag_add,
           out_real_sub, out_imag_sub, sat_flag
  );

  modport slave (
    input  in_valid, a_real, a_imag, b_real, b_imag,
           rotation_factor_real, rotation_factor_imag, out_ready, sat_clear,
    output in_ready, out_valid, out_real_add, out_imag_add,
           out_real_sub, out_imag_sub, sat_flag
  );
endinterface

// File: rtl/ifft_butterfly_pipe.sv
// Three-stage radix-2 DIF butterfly for the inverse FFT:
// add = (a+b)/2^SCALE, sub = (a-b)*conj(W)/2^SCALE, floor rounding, saturating.
module ifft_butterfly_pipe #(
  parameter int SCALE = 1,
  parameter int DW    = 32
) (
  input logic                  clk,
  input logic                  rst,
  ifft_butterfly_pipe_if.slave bus
);
  localparam int SW     = DW + 1;
  localparam int PW     = 2 * DW + 1;
  localparam int RW     = 2 * DW + 2;
  localparam int SUB_SH = 16 + SCALE;

  logic en;
  logic v1_q, v2_q, out_valid_q, sat_flag_q;

  logic signed [SW-1:0] sum_re_d, sum_im_d, dif_re_d, dif_im_d;
  logic signed [SW-1:0] sum_re_q, sum_im_q, dif_re_q, dif_im_q;
  logic signed [DW-1:0] w_re_q, w_im_q;

  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ir_d, p_ri_d;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic signed [SW-1:0] sum2_re_q, sum2_im_q;

  logic signed [RW-1:0] pr_w, pi_w;
  logic [3:0]           sat_d;
  logic [DW-1:0]        add_re_d, add_im_d, sub_re_d, sub_im_d;
  logic [DW-1:0]        add_re_q, add_im_q, sub_re_q, sub_im_q;

  // Returns {saturated, value}: in range iff every bit from DW-1 upward matches the sign.
  function automatic logic [DW:0] clamp(input logic signed [RW-1:0] x);
    logic [DW:0] r;
    if ((&x[RW-1:DW-1]) || !(|x[RW-1:DW-1])) r = {1'b0, x[DW-1:0]};
    else if (x[RW-1])                        r = {1'b1, 1'b1, {(DW-1){1'b0}}};
    else                                     r = {1'b1, 1'b0, {(DW-1){1'b1}}};
    return r;
  endfunction

  assign en                = !out_valid_q || bus.out_ready;
  assign bus.in_ready      = en;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_real_add  = add_re_q;
  assign bus.out_imag_add  = add_im_q;
  assign bus.out_real_sub  = sub_re_q;
  assign bus.out_imag_sub  = sub_im_q;
  assign bus.sat_flag      = sat_flag_q;

  always_comb begin
    sum_re_d = {bus.a_real[DW-1], bus.a_real} + {bus.b_real[DW-1], bus.b_real};
    sum_im_d = {bus.a_imag[DW-1], bus.a_imag} + {bus.b_imag[DW-1], bus.b_imag};
    dif_re_d = {bus.a_real[DW-1], bus.a_real} - {bus.b_real[DW-1], bus.b_real};
    dif_im_d = {bus.a_imag[DW-1], bus.a_imag} - {bus.b_imag[DW-1], bus.b_imag};
  end

  always_comb begin
    p_rr_d = PW'(dif_re_q) * PW'(w_re_q);
    p_ii_d = PW'(dif_im_q) * PW'(w_im_q);
    p_ir_d = PW'(dif_im_q) * PW'(w_re_q);
    p_ri_d = PW'(dif_re_q) * PW'(w_im_q);
  end

  // conj(W) flips the sign of wi: pr = dr*wr + di*wi, pi = di*wr - dr*wi.
  always_comb begin
    pr_w = RW'(p_rr_q) + RW'(p_ii_q);
    pi_w = RW'(p_ir_q) - RW'(p_ri_q);
    {sat_d[0], add_re_d} = clamp(RW'(sum2_re_q) >>> SCALE);
    {sat_d[1], add_im_d} = clamp(RW'(sum2_im_q) >>> SCALE);
    {sat_d[2], sub_re_d} = clamp(pr_w >>> SUB_SH);
    {sat_d[3], sub_im_d} = clamp(pi_w >>> SUB_SH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      sum_re_q  <= '0;
      sum_im_q  <= '0;
      dif_re_q  <= '0;
      dif_im_q  <= '0;
      w_re_q    <= '0;
      w_im_q    <= '0;
      v2_q      <= 1'b0;
      p_rr_q    <= '0;
      p_ii_q    <= '0;
      p_ir_q    <= '0;
      p_ri_q    <= '0;
      sum2_re_q <= '0;
      sum2_im_q <= '0;
    end else if (en) begin
      v1_q      <= bus.in_valid;
      sum_re_q  <= sum_re_d;
      sum_im_q  <= sum_im_d;
      dif_re_q  <= dif_re_d;
      dif_im_q  <= dif_im_d;
      w_re_q    <= bus.rotation_factor_real;
      w_im_q    <= bus.rotation_factor_imag;
      v2_q      <= v1_q;
      p_rr_q    <= p_rr_d;
      p_ii_q    <= p_ii_d;
      p_ir_q    <= p_ir_d;
      p_ri_q    <= p_ri_d;
      sum2_re_q <= sum_re_q;
      sum2_im_q <= sum_im_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      add_re_q    <= '0;
      add_im_q    <= '0;
      sub_re_q    <= '0;
      sub_im_q    <= '0;
    end else if (en) begin
      out_valid_q <= v2_q;
      add_re_q    <= add_re_d;
      add_im_q    <= add_im_d;
      sub_re_q    <= sub_re_d;
      sub_im_q    <= sub_im_d;
    end
  end

  // Setting has priority over a same-cycle clear so no saturation event is lost.
  always_ff @(posedge clk) begin
    if (rst)                           sat_flag_q <= 1'b0;
    else if (en && v2_q && (|sat_d))   sat_flag_q <= 1'b1;
    else if (bus.sat_clear)            sat_flag_q <= 1'b0;
  end
endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Scoreboard bench for ifft_butterfly_pipe: a SCALE=1 and a SCALE=0 instance,
// directed vectors with hand-computed results plus a short random burst.
module tb_ifft_butterfly_pipe;
  typedef struct {
    logic [31:0] ar;
    logic [31:0] ai;
    logic [31:0] sr;
    logic [31:0] si;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   max_run = 0;
  exp_t q[2][$];

  always #5 clk = ~clk;

  ifft_butterfly_pipe_if #(.DW(32)) b1 ();
  ifft_butterfly_pipe_if #(.DW(32)) b0 ();

  ifft_butterfly_pipe #(.SCALE(1), .DW(32)) u_s1 (.clk(clk), .rst(rst), .bus(b1));
  ifft_butterfly_pipe #(.SCALE(0), .DW(32)) u_s0 (.clk(clk), .rst(rst), .bus(b0));

  function automatic exp_t mk(input logic [31:0] ar, ai, sr, si);
    exp_t e;
    e.ar = ar; e.ai = ai; e.sr = sr; e.si = si;
    return e;
  endfunction

  function automatic logic signed [127:0] sx(input logic [31:0] v);
    return {{96{v[31]}}, v};
  endfunction

  function automatic logic [31:0] sat32(input logic signed [127:0] v);
    logic [31:0] r;
    if (v > 128'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (v < -128'sd2147483648) r = 32'h8000_0000;
    else                            r = v[31:0];
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] ar, ai, br, bi, wr, wi, input int sc);
    logic signed [127:0] dr, di, pr, pi;
    exp_t e;
    dr = sx(ar) - sx(br);
    di = sx(ai) - sx(bi);
    pr = dr * sx(wr) + di * sx(wi);
    pi = di * sx(wr) - dr * sx(wi);
    e.ar = sat32((sx(ar) + sx(br)) >>> sc);
    e.ai = sat32((sx(ai) + sx(bi)) >>> sc);
    e.sr = sat32(pr >>> (16 + sc));
    e.si = sat32(pi >>> (16 + sc));
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic mon(input int d);
    logic ov, ordy, ir;
    logic [31:0] o_ar, o_ai, o_sr, o_si;
    exp_t e;
    if (d == 1) begin
      ov = b1.out_valid; ordy = b1.out_ready; ir = b1.in_ready;
      o_ar = b1.out_real_add; o_ai = b1.out_imag_add;
      o_sr = b1.out_real_sub; o_si = b1.out_imag_sub;
    end else begin
      ov = b0.out_valid; ordy = b0.out_ready; ir = b0.in_ready;
      o_ar = b0.out_real_add; o_ai = b0.out_imag_add;
      o_sr = b0.out_real_sub; o_si = b0.out_imag_sub;
    end
    chk($sformatf("in_ready[%0d]", d), {31'b0, ir}, {31'b0, !ov || ordy});
    if (d == 1) begin
      run_len = (ov && ordy) ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
    end
    if (ov) begin
      if (q[d].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out[%0d] actual=valid expected=none", d);
      end else begin
        e = q[d][0];
        chk($sformatf("add_re[%0d]", d), o_ar, e.ar);
        chk($sformatf("add_im[%0d]", d), o_ai, e.ai);
        chk($sformatf("sub_re[%0d]", d), o_sr, e.sr);
        chk($sformatf("sub_im[%0d]", d), o_si, e.si);
        if (ordy) void'(q[d].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst) run_len = 0;
    else begin
      mon(1);
      mon(0);
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input int d, input logic [31:0] ar, ai, br, bi, wr, wi, input exp_t e);
    logic ir;
    if (d == 1) begin
      b1.in_valid = 1'b1; b1.a_real = ar; b1.a_imag = ai; b1.b_real = br; b1.b_imag = bi;
      b1.rotation_factor_real = wr; b1.rotation_factor_imag = wi;
    end else begin
      b0.in_valid = 1'b1; b0.a_real = ar; b0.a_imag = ai; b0.b_real = br; b0.b_imag = bi;
      b0.rotation_factor_real = wr; b0.rotation_factor_imag = wi;
    end
    for (int t = 0; t < 100; t++) begin
      #1;
      ir = (d == 1) ? b1.in_ready : b0.in_ready;
      if (ir) begin
        q[d].push_back(e);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL send_timeout[%0d] actual=no_ready expected=ready", d);
  endtask

  task automatic idle();
    b1.in_valid = 1'b0;
    b0.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #3;
      if (q[0].size() == 0 && q[1].size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout actual=%0d/%0d expected=0/0", q[0].size(), q[1].size());
  endtask

  initial begin
    logic [31:0] r [6];
    b1.in_valid = 0; b1.a_real = 0; b1.a_imag = 0; b1.b_real = 0; b1.b_imag = 0;
    b1.rotation_factor_real = 0; b1.rotation_factor_imag = 0; b1.out_ready = 1; b1.sat_clear = 0;
    b0.in_valid = 0; b0.a_real = 0; b0.a_imag = 0; b0.b_real = 0; b0.b_imag = 0;
    b0.rotation_factor_real = 0; b0.rotation_factor_imag = 0; b0.out_ready = 1; b0.sat_clear = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, b1.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, b1.in_ready}, 32'd1);
    chk("rst_sat_flag", {31'b0, b1.sat_flag}, 32'd0);
    chk("rst_add_re", b1.out_real_add, 32'd0);
    chk("rst_sub_im", b1.out_imag_sub, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Real twiddle, with exact latency check.
    send(1, 32'h0001_0000, 0, 32'h0000_8000, 0, 32'h0001_0000, 0,
         mk(32'h0000_C000, 0, 32'h0000_4000, 0));
    idle();
    #1 chk("lat_edge1", {31'b0, b1.out_valid}, 32'd0);
    @(negedge clk);
    #1 chk("lat_edge2", {31'b0, b1.out_valid}, 32'd0);
    @(negedge clk);
    #1 chk("lat_edge3", {31'b0, b1.out_valid}, 32'd1);
    drain();
    chk("t1_sat_flag", {31'b0, b1.sat_flag}, 32'd0);

    // Conjugate twiddle: W = -j must rotate by +j.
    send(1, 32'h0001_0000, 0, 0, 0, 0, 32'hFFFF_0000, mk(32'h0000_8000, 0, 0, 32'h0000_8000));
    // Floor of -0.5 LSB.
    send(1, 32'hFFFF_FFFF, 0, 0, 0, 32'h0001_0000, 0, mk(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0));
    idle();
    drain();

    // Saturation on the unscaled instance, sticky until cleared.
    send(0, 32'h7FFF_0000, 0, 32'h7FFF_0000, 0, 32'h0001_0000, 0, mk(32'h7FFF_FFFF, 0, 0, 0));
    idle();
    drain();
    chk("s0_sat_set", {31'b0, b0.sat_flag}, 32'd1);
    repeat (2) @(negedge clk);
    #1 chk("s0_sat_sticky", {31'b0, b0.sat_flag}, 32'd1);
    @(negedge clk);
    b0.sat_clear = 1'b1;
    @(negedge clk);
    b0.sat_clear = 1'b0;
    #1 chk("s0_sat_cleared", {31'b0, b0.sat_flag}, 32'd0);

    send(1, 32'h7FFF_0000, 0, 32'h7FFF_0000, 0, 32'h0001_0000, 0, mk(32'h7FFF_0000, 0, 0, 0));
    idle();
    drain();
    chk("s1_no_sat", {31'b0, b1.sat_flag}, 32'd0);

    // Back-pressure: six beats with a stall window in the middle.
    fork
      begin
        for (int n = 1; n <= 6; n++) begin
          logic [31:0] nv;
          nv = 32'(n);
          send(1, nv << 16, 0, 0, 0, 32'h0001_0000, 0, mk(nv * 32'h8000, 0, nv * 32'h8000, 0));
        end
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        b1.out_ready = 1'b0;
        repeat (6) @(negedge clk);
        b1.out_ready = 1'b1;
      end
    join
    drain();

    // Back-to-back full rate against the wide reference model.
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 6; k++) r[k] = $urandom;
      send(1, r[0], r[1], r[2], r[3], r[4], r[5], model(r[0], r[1], r[2], r[3], r[4], r[5], 1));
    end
    idle();
    drain();
    chk("full_rate_run", {31'b0, max_run >= 16}, 32'd1);

    // Reset mid-operation: set sat_flag first, then drop two in-flight beats.
    send(1, 32'h7FFF_0000, 0, 32'h8001_0000, 0, 32'h0002_0000, 0, mk(0, 0, 32'h7FFF_FFFF, 0));
    idle();
    drain();
    chk("pre_rst_sat", {31'b0, b1.sat_flag}, 32'd1);
    send(1, 32'h0001_0000, 0, 0, 0, 32'h0001_0000, 0, mk(32'h8000, 0, 32'h8000, 0));
    send(1, 32'h0002_0000, 0, 0, 0, 32'h0001_0000, 0, mk(32'h10000, 0, 32'h10000, 0));
    idle();
    rst = 1'b1;
    q[1].delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, b1.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, b1.in_ready}, 32'd1);
    chk("mid_rst_sat_flag", {31'b0, b1.sat_flag}, 32'd0);
    chk("mid_rst_add_re", b1.out_real_add, 32'd0);
    chk("mid_rst_sub_re", b1.out_real_sub, 32'd0);
    repeat (6) @(negedge clk);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
